// File: rtl/booth_pkg.sv
// Shared types, constants and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  // Controller states; 2-bit encoding leaves one unreachable code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Booth pair {Q[0], q_m1} values that modify the accumulator.
  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

  // Widest operand the extension helper supports.
  localparam int MAX_WIDTH = 32;

  // Extend a width-bit operand (right-aligned in value) to MAX_WIDTH+1 bits,
  // replicating its MSB for signed operands and filling zeros otherwise.
  function automatic logic [MAX_WIDTH:0] ext_op(input logic [MAX_WIDTH-1:0] value,
                                                input logic                 is_signed,
                                                input int                   width);
    logic [MAX_WIDTH:0] res;
    logic               fill;
    fill = is_signed & value[5'(width - 1)];
    for (int i = 0; i < MAX_WIDTH; i++) begin
      res[i] = (i < width) ? value[i] : fill;
    end
    res[MAX_WIDTH] = fill;
    return res;
  endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// One Booth iteration: conditional add/subtract of M into A followed by an
// arithmetic right shift of {A, Q, q_m1}. Purely combinational.
module booth_step
  import booth_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] q_i,
  input  logic         qm1_i,
  input  logic [N-1:0] m_i,
  output logic [N-1:0] a_o,
  output logic [N-1:0] q_o,
  output logic         qm1_o
);

  logic [N-1:0] sum;

  // Select A-M, A+M or A from the current Booth pair; modulo 2^N arithmetic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    sum = a_i;
    case ({q_i[0], qm1_i})
      BOOTH_SUB: sum = a_i - m_i;
      BOOTH_ADD: sum = a_i + m_i;
      default:   sum = a_i;
    endcase
  end

  // Arithmetic shift right of {sum, Q, q_m1}: A's MSB is replicated.
  assign a_o   = {sum[N-1], sum[N-1:1]};
  assign q_o   = {sum[0], q_i[N-1:1]};
  assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one iteration per clock, with a
// per-operation signed/unsigned mode, busy/done handshake and held result.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   result_o
);

  // Extended operands are one bit wider than the inputs, so both signed and
  // unsigned values become non-overflowing N-bit two's-complement numbers.
  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);

  state_t             state_q;
  logic [N-1:0]       a_q;
  logic [N-1:0]       q_q;
  logic               qm1_q;
  logic [N-1:0]       m_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] result_q;

  logic [N-1:0]       a_d;
  logic [N-1:0]       q_d;
  logic               qm1_d;
  logic [2*WIDTH-1:0] result_d;
  logic [N-1:0]       m_ext;
  logic [N-1:0]       q_ext;
  logic               last_iter;

  assign m_ext = N'(ext_op(32'(multiplicand_i), signed_i, WIDTH));
  assign q_ext = N'(ext_op(32'(multiplier_i), signed_i, WIDTH));

  booth_step #(.N(N)) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (a_d),
    .q_o   (q_d),
    .qm1_o (qm1_d)
  );

  // The true product fits in 2*WIDTH bits, so the top two bits of {A,Q} are dropped.
  assign result_d  = (2*WIDTH)'({a_d, q_d});
  assign last_iter = (count_q == CW'(N - 1));

  // Controller and datapath registers; outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= '0;
            q_q     <= q_ext;
            qm1_q   <= 1'b0;
            m_q     <= m_ext;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_d;
          q_q     <= q_d;
          qm1_q   <= qm1_d;
          count_q <= count_q + CW'(1);
          if (last_iter) begin
            result_q <= result_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH = 4, 8 and 16, against a
// cycle-level behavioural model built on plain integer multiplication.
module tb_booth_mult_seq;

  localparam int WID [3] = '{4, 8, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic [2:0]  sgn_v   = 3'b000;
  logic [31:0] a_v [3] = '{32'd0, 32'd0, 32'd0};
  logic [31:0] b_v [3] = '{32'd0, 32'd0, 32'd0};

  wire  [2:0]  busy_w;
  wire  [2:0]  done_w;
  wire  [7:0]  r4;
  wire  [15:0] r8;
  wire  [31:0] r16;
  logic [63:0] res_all [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .signed_i(sgn_v[0]),
    .multiplicand_i(a_v[0][3:0]), .multiplier_i(b_v[0][3:0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .result_o(r4));

  booth_mult_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .signed_i(sgn_v[1]),
    .multiplicand_i(a_v[1][7:0]), .multiplier_i(b_v[1][7:0]),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .result_o(r8));

  booth_mult_seq #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .signed_i(sgn_v[2]),
    .multiplicand_i(a_v[2][15:0]), .multiplier_i(b_v[2][15:0]),
    .busy_o(busy_w[2]), .done_o(done_w[2]), .result_o(r16));

  always_comb begin
    res_all[0] = 64'(r4);
    res_all[1] = 64'(r8);
    res_all[2] = 64'(r16);
  end

  // Reference product: interpret operands as w-bit signed or unsigned integers,
  // multiply, and keep the low 2*w bits.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic sg, input int w);
    longint      sa, sb;
    logic [63:0] p, mask;
    sa = longint'(a) & ((longint'(1) << w) - 1);
    sb = longint'(b) & ((longint'(1) << w) - 1);
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    p    = 64'(sa * sb);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return p & mask;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a started operation is busy for N cycles, then done for
  // one cycle with its product; the result register holds between completions.
  int          phase [3]    = '{0, 0, 0};  // 0 idle, 1 running, 2 done
  int          left [3]     = '{0, 0, 0};
  logic [63:0] pending [3]  = '{64'd0, 64'd0, 64'd0};
  logic [63:0] m_result [3] = '{64'd0, 64'd0, 64'd0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        phase[i]    <= 0;
        left[i]     <= 0;
        m_result[i] <= 64'd0;
      end else if (phase[i] == 1) begin
        left[i] <= left[i] - 1;
        if (left[i] == 1) begin
          m_result[i] <= pending[i];
          phase[i]    <= 2;
        end
      end else if (start_v[i]) begin
        pending[i] <= ref_prod(a_v[i], b_v[i], sgn_v[i], WID[i]);
        left[i]    <= WID[i] + 1;
        phase[i]   <= 1;
      end else begin
        phase[i] <= 0;
      end
    end
  end

  // Every-cycle comparison of all three DUTs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("w%0d busy_o", WID[i]), 64'(busy_w[i]), 64'(phase[i] == 1));
      check($sformatf("w%0d done_o", WID[i]), 64'(done_w[i]), 64'(phase[i] == 2));
      check($sformatf("w%0d result_o", WID[i]), res_all[i], m_result[i]);
    end
  end

  task automatic wait_done(input int i, output int e);
    e = 0;
    while (!done_w[i] && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    if (!done_w[i]) check($sformatf("w%0d done timeout", WID[i]), 64'd0, 64'd1);
  endtask

  // Start one operation, scramble the inputs after capture, optionally hold
  // start into RUN, and wait for done. lat counts edges after the start edge.
  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input int hold,
                        output logic [63:0] res, output int lat, output int bc);
    a_v[i] = a; b_v[i] = b; sgn_v[i] = sg; start_v[i] = 1'b1;
    @(posedge clk); #1;
    a_v[i] = $urandom; b_v[i] = $urandom; sgn_v[i] = ~sg;
    if (hold == 0) start_v[i] = 1'b0;
    bc  = int'(busy_w[i]);
    lat = 0;
    while (!done_w[i] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= hold) start_v[i] = 1'b0;
      bc += int'(busy_w[i]);
    end
    if (!done_w[i]) check($sformatf("w%0d done timeout", WID[i]), 64'd0, 64'd1);
    res = res_all[i];
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    int          lat, bc, e, e2;
    logic [31:0] a, b, mask;
    logic        sg;

    // Reset state while rst is held.
    @(posedge clk); #1;
    check("reset busy_o", 64'(busy_w[1]), 64'd0);
    check("reset done_o", 64'(done_w[1]), 64'd0);
    check("reset result_o", 64'(r8), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // -3 x 5 signed: latency and busy length.
    run_op(1, 32'hFD, 32'h05, 1'b1, 0, res, lat, bc);
    check("-3x5 result", res, 64'hFFF1);
    check("-3x5 latency", 64'(lat), 64'd9);
    check("-3x5 busy cycles", 64'(bc), 64'd9);

    run_op(1, 32'h80, 32'h80, 1'b1, 0, res, lat, bc);
    check("-128x-128 signed", res, 64'h4000);
    run_op(1, 32'h80, 32'h80, 1'b0, 0, res, lat, bc);
    check("128x128 unsigned", res, 64'h4000);
    run_op(1, 32'h80, 32'h02, 1'b0, 0, res, lat, bc);
    check("0x80x2 unsigned", res, 64'h0100);
    run_op(1, 32'h80, 32'h02, 1'b1, 0, res, lat, bc);
    check("0x80x2 signed", res, 64'hFF00);
    run_op(1, 32'hFF, 32'hFF, 1'b0, 0, res, lat, bc);
    check("255x255 unsigned", res, 64'hFE01);
    run_op(1, 32'h00, 32'hC8, 1'b0, 0, res, lat, bc);
    check("0x200 unsigned", res, 64'h0000);

    // start pulsed mid-RUN with other operands is ignored.
    a_v[1] = 32'd3; b_v[1] = 32'd4; sgn_v[1] = 1'b0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_v[1] = 32'd9; b_v[1] = 32'd9; start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    wait_done(1, e);
    check("start in RUN latency", 64'(e + 3), 64'd9);
    check("start in RUN result", res_all[1], 64'h000C);
    @(posedge clk); #1;

    // start held high through DONE: back-to-back operation.
    a_v[1] = 32'd5; b_v[1] = 32'd6; sgn_v[1] = 1'b0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    wait_done(1, e);
    check("b2b first latency", 64'(e), 64'd9);
    check("b2b first result", res_all[1], 64'h001E);
    a_v[1] = 32'd10; b_v[1] = 32'd11;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    check("b2b reload busy_o", 64'(busy_w[1]), 64'd1);
    check("b2b reload done_o", 64'(done_w[1]), 64'd0);
    wait_done(1, e2);
    check("b2b done spacing", 64'(e2 + 1), 64'd10);
    check("b2b second result", res_all[1], 64'h006E);
    @(posedge clk); #1;

    // Reset asserted in the 4th RUN cycle aborts the operation at once.
    a_v[1] = 32'hFD; b_v[1] = 32'h05; sgn_v[1] = 1'b1; start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy_o", 64'(busy_w[1]), 64'd0);
    check("abort done_o", 64'(done_w[1]), 64'd0);
    check("abort result_o", 64'(r8), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1, 32'h07, 32'hFA, 1'b1, 0, res, lat, bc);
    check("7x-6 after abort", res, 64'hFFD6);
    check("7x-6 latency", 64'(lat), 64'd9);

    // Random sweeps at WIDTH 4 and 16, with boundary values mixed in.
    for (int s = 0; s < 2; s++) begin
      int i;
      i    = (s == 0) ? 0 : 2;
      mask = 32'((64'd1 << WID[i]) - 64'd1);
      for (int k = 0; k < 1000; k++) begin
        sg = 1'($urandom_range(0, 1));
        a  = $urandom & mask;
        b  = $urandom & mask;
        if (k % 8 == 0) begin
          case ($urandom_range(0, 3))
            0: a = mask;
            1: a = 32'd1 << (WID[i] - 1);
            2: a = 32'd0;
            default: a = 32'd1;
          endcase
          b = ($urandom_range(0, 1) == 0) ? mask : (32'd1 << (WID[i] - 1));
        end
        run_op(i, a, b, sg, $urandom_range(0, 3), res, lat, bc);
        check($sformatf("w%0d rand %h*%h s%0d", WID[i], a, b, sg), res,
              ref_prod(a, b, sg, WID[i]));
        check($sformatf("w%0d rand latency", WID[i]), 64'(lat), 64'(WID[i] + 1));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier, one iteration per clock. It generalises the fixed 4-bit multiplier to any operand width. It adds a per-operation signed/unsigned mode, a busy/done handshake and a held result register. Used as a shared low-area multiplier wherever a multi-cycle product is acceptable.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
N (localparam), WIDTH+1, number of iterations; also the width of the extended operands.
CW (localparam), $clog2(WIDTH+2), iteration counter width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
signed_i  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
multiplicand_i  input  WIDTH  multiplicand; captured with start
multiplier_i  input  WIDTH  multiplier; captured with start
busy_o  output  1  high while in RUN
done_o  output  1  one-cycle pulse, result_o valid
result_o  output  2*WIDTH  product, held until the next completion

Behaviour:
- Reset (async, active-high): state=IDLE; busy_o=0, done_o=0, result_o=0; accumulator, Q, q_m1 and count cleared. Outputs stay at these values while rst is high.
- Operand extension to N bits at capture:
  - signed_i=1: sign-extend.
  - signed_i=0: zero-extend.
  - Operands are captured into internal registers, so input changes after the start edge have no effect.
- Datapath registers:
  - A: N bits, starts at 0.
  - Q: N bits, loaded with the extended multiplier.
  - q_m1: 1 bit, starts at 0.
  - M: N bits, the extended multiplicand.
- One iteration, per RUN edge:
  - {Q[0],q_m1} = 10: A=A-M.
  - {Q[0],q_m1} = 01: A=A+M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_m1} by one bit. A's MSB is replicated.
  - Add/sub and shift complete in the same cycle (the fixed multiplier split them).
  - Arithmetic is modulo 2^N. Extended operands never equal -2^WIDTH, so no overflow is possible.
- FSM:
  - IDLE: start=1 loads registers, count=0, next state RUN. Otherwise stay in IDLE.
  - RUN: busy_o=1. Each edge performs one iteration and increments count. On the edge performing iteration N (count==N-1), the low 2*WIDTH bits of {A,Q} go to result_o and the next state is DONE.
  - DONE: done_o=1 for exactly one cycle; busy_o=0. start=1 here loads a new operation and goes to RUN (back-to-back). Otherwise go to IDLE.
  - Unreachable encodings go to IDLE.
- Latency:
  - Start sampled at edge k; iterations run on edges k+1..k+N.
  - done_o is high in the cycle after edge k+N.
  - Throughput is one product per N+1 cycles.
- start during RUN is ignored; no queuing and no error flag.
- result_o changes only on the final RUN edge. Its previous value holds through IDLE and RUN.
- Width rule: the true product always fits in 2*WIDTH bits in both modes.
  - Unsigned maximum: (2^W-1)^2.
  - Signed: (-2^(W-1))^2 = 2^(2W-2).
  - The upper two bits of {A,Q} are discarded.
- Reset mid-RUN aborts the operation. result_o returns to 0 and no done_o pulse is produced.

Decomposition:
- Package booth_pkg holds:
  - the state typedef (IDLE, RUN, DONE; 2-bit encoding)
  - the Booth-pair constants (BOOTH_SUB=2'b10, BOOTH_ADD=2'b01)
  - a function ext_op(value, signed, width) for operand extension.
- One natural sub-module, booth_step: a purely combinational N-bit add/sub plus arithmetic shift of {A,Q,q_m1}. It is instantiated once; the FSM and registers stay in booth_mult_seq.

Test Plan:
- WIDTH=8, signed, -3 x 5 -> result_o=16'hFFF1 (-15). done_o is high exactly 9 edges after the start edge, and busy_o is high for 9 cycles.
- WIDTH=8, signed, -128 x -128 -> 16'h4000. Same operands unsigned (128 x 128) -> 16'h4000. Then unsigned 8'h80 x 8'h02 -> 16'h0100 vs signed -> 16'hFF00.
- WIDTH=8, unsigned 255 x 255 -> 16'hFE01. 0 x 200 -> 16'h0000.
- Start during RUN with different operands -> ignored; the first product completes. Start held high in DONE -> back-to-back product and a second done_o pulse N+1 cycles later.
- Reset asserted in the 4th RUN cycle -> busy_o=0 and result_o=0 immediately (async), no done_o. A subsequent 7 x -6 signed -> 16'hFFD6.
- WIDTH=4 and WIDTH=16, random signed/unsigned operand sweep (at least 1000 each) against a reference model -> all products match; latency is always N edges.
